// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: ROM address/data pair plus the valid/ready instruction
// stream handed to the decode stage.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    // The fetch controller drives the ROM address and the instruction stream.
    modport master (
        output rom_addr,
        input  rom_data,
        output inst_out,
        output inst_pc,
        output inst_valid,
        input  inst_ready
    );

    // The ROM and the decode stage sit on the other side.
    modport slave (
        input  rom_addr,
        output rom_data,
        input  inst_out,
        input  inst_pc,
        input  inst_valid,
        output inst_ready
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the ROM pc, steps through the ROM and
// presents fetched words through a single-entry valid/ready output register.
module inst_fetch_ctrl #(
    parameter int              ADDR_W     = 4,
    parameter int              DATA_W     = 8,
    parameter int              START_ADDR = 0,
    parameter int              WRAP_ADDR  = 1,
    parameter logic [DATA_W-1:0] HALT_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    inst_fetch_ctrl_if.master bus,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] WRAP_PC  = ADDR_W'(WRAP_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PC  = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_out_q, inst_out_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;

    logic              transfer;
    logic              load;
    logic [ADDR_W-1:0] pc_next;

    // The last ROM address wraps to WRAP_PC rather than rolling over to zero.
    always_comb begin
        pc_next = pc_q + ADDR_W'(1);
        if (pc_q == LAST_PC) begin
            pc_next = WRAP_PC;
        end
    end

    always_comb begin
        transfer = inst_valid_q && bus.inst_ready;
        load     = (state_q == ST_RUN) && !stall && !jump_en
                   && (!inst_valid_q || bus.inst_ready);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                end
            end

            // Jump outranks stall and load and flushes any unaccepted word.
            ST_RUN: begin
                if (jump_en) begin
                    pc_d         = jump_addr;
                    inst_valid_d = 1'b0;
                end else if (load) begin
                    inst_out_d   = bus.rom_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    if (bus.rom_data == HALT_OP) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_next;
                    end
                end else if (transfer) begin
                    inst_valid_d = 1'b0;
                end
            end

            // A restart from HALT drops a HALT_OP that was never accepted.
            ST_HALT: begin
                if (start) begin
                    state_d      = ST_RUN;
                    pc_d         = START_PC;
                    inst_valid_d = 1'b0;
                end else if (transfer) begin
                    inst_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        bus.rom_addr   = pc_q;
        bus.inst_out   = inst_out_q;
        bus.inst_pc    = inst_pc_q;
        bus.inst_valid = inst_valid_q;
        busy           = (state_q == ST_RUN);
        halted         = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a cycle-level reference model
// compared every cycle, plus directed scenarios with hand-derived values.
module tb_inst_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stall;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       inst_ready;
    logic       busy;
    logic       halted;
    logic [7:0] rom [16];

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    inst_fetch_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    assign bus.rom_data   = rom[bus.rom_addr];
    assign bus.inst_ready = inst_ready;

    inst_fetch_ctrl #(
        .ADDR_W(4), .DATA_W(8), .START_ADDR(0), .WRAP_ADDR(1), .HALT_OP(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .jump_en(jump_en), .jump_addr(jump_addr), .bus(bus),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    int         m_mode  = 0;
    logic [3:0] m_pc    = '0;
    logic [3:0] m_ipc   = '0;
    logic [7:0] m_out   = '0;
    bit         m_valid = 1'b0;
    logic [7:0] m_word;
    bit         m_taken;

    always @(posedge clk) begin
        m_taken = m_valid && inst_ready;
        m_word  = rom[m_pc];
        if (rst) begin
            m_mode = 0; m_pc = 0; m_ipc = 0; m_out = 0; m_valid = 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_pc = 0; end
        end else if (m_mode == 1) begin
            if (jump_en) begin
                m_pc = jump_addr; m_valid = 0;
            end else if (!stall && (!m_valid || inst_ready)) begin
                m_out = m_word; m_ipc = m_pc; m_valid = 1;
                if (m_word == 8'hFF) m_mode = 2;
                else m_pc = (m_pc == 4'd15) ? 4'd1 : m_pc + 4'd1;
            end else if (m_taken) begin
                m_valid = 0;
            end
        end else begin
            if (start) begin m_mode = 1; m_pc = 0; m_valid = 0; end
            else if (m_taken) m_valid = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check_output("model.rom_addr", 32'(bus.rom_addr), 32'(m_pc));
            check_output("model.inst_valid", 32'(bus.inst_valid), 32'(m_valid));
            check_output("model.busy", 32'(busy), 32'(m_mode == 1));
            check_output("model.halted", 32'(halted), 32'(m_mode == 2));
            if (m_valid) begin
                check_output("model.inst_out", 32'(bus.inst_out), 32'(m_out));
                check_output("model.inst_pc", 32'(bus.inst_pc), 32'(m_ipc));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_rom(input int halt_at);
        for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
        if (halt_at >= 0) rom[halt_at] = 8'hFF;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; jump_en = 1'b0;
        jump_addr = '0; inst_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance until inst_pc == target is being presented, bounded.
    task automatic wait_inst_pc(input logic [3:0] target);
        int n = 0;
        while (!(bus.inst_valid && bus.inst_pc == target) && n < 40) begin
            tick();
            n++;
        end
        check_output("wait_inst_pc.timeout", 32'(n < 40), 32'd1);
    endtask

    initial begin
        load_rom(-1);
        apply_reset();
        model_on = 1'b1;

        // Reset state
        check_output("reset.valid", 32'(bus.inst_valid), 32'd0);
        check_output("reset.rom_addr", 32'(bus.rom_addr), 32'd0);
        check_output("reset.inst_out", 32'(bus.inst_out), 32'd0);
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.halted", 32'(halted), 32'd0);

        // Free run with wrap to address 1
        apply_start();
        check_output("run.busy", 32'(busy), 32'd1);
        check_output("run.first_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        for (int i = 0; i < 18; i++) begin
            int e;
            e = (i < 16) ? i : i - 15;
            check_output("run.valid", 32'(bus.inst_valid), 32'd1);
            check_output("run.inst_pc", 32'(bus.inst_pc), 32'(e));
            check_output("run.inst_out", 32'(bus.inst_out), 32'h10 + 32'(e));
            tick();
        end

        // Backpressure at inst_pc 4
        apply_reset();
        apply_start();
        wait_inst_pc(4'd4);
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) inst_ready = 1'b1;
            check_output("bp.hold_out", 32'(bus.inst_out), 32'h14);
            check_output("bp.hold_pc", 32'(bus.inst_pc), 32'd4);
            check_output("bp.rom_addr", 32'(bus.rom_addr), 32'd5);
            tick();
        end
        check_output("bp.next_out", 32'(bus.inst_out), 32'h15);
        check_output("bp.next_valid", 32'(bus.inst_valid), 32'd1);

        // Jump to 9 while holding an unaccepted word
        apply_reset();
        apply_start();
        wait_inst_pc(4'd3);
        inst_ready = 1'b0; jump_en = 1'b1; jump_addr = 4'd9;
        tick();
        jump_en = 1'b0; inst_ready = 1'b1;
        check_output("jump.flush", 32'(bus.inst_valid), 32'd0);
        check_output("jump.rom_addr", 32'(bus.rom_addr), 32'd9);
        tick();
        check_output("jump.out9", 32'(bus.inst_out), 32'h19);
        check_output("jump.pc9", 32'(bus.inst_pc), 32'd9);
        tick();
        check_output("jump.pc10", 32'(bus.inst_pc), 32'd10);

        // Halt on ROM[5], jump ignored in HALT, restart
        load_rom(5);
        apply_reset();
        apply_start();
        wait_inst_pc(4'd5);
        check_output("halt.out", 32'(bus.inst_out), 32'hFF);
        check_output("halt.halted", 32'(halted), 32'd1);
        check_output("halt.busy", 32'(busy), 32'd0);
        jump_en = 1'b1; jump_addr = 4'd12;
        tick();
        jump_en = 1'b0;
        check_output("halt.accepted", 32'(bus.inst_valid), 32'd0);
        check_output("halt.rom_addr", 32'(bus.rom_addr), 32'd5);
        tick();
        check_output("halt.stays", 32'(halted), 32'd1);
        apply_start();
        check_output("halt.restart_addr", 32'(bus.rom_addr), 32'd0);
        tick();
        check_output("halt.restart_out", 32'(bus.inst_out), 32'h10);

        // Stall at pc 7, then stall together with jump to 2
        load_rom(-1);
        apply_reset();
        apply_start();
        wait_inst_pc(4'd6);
        check_output("stall.pre_addr", 32'(bus.rom_addr), 32'd7);
        stall = 1'b1;
        tick();
        tick();
        check_output("stall.hold_addr", 32'(bus.rom_addr), 32'd7);
        check_output("stall.no_load", 32'(bus.inst_valid), 32'd0);
        jump_en = 1'b1; jump_addr = 4'd2;
        tick();
        jump_en = 1'b0; stall = 1'b0;
        check_output("stall.jump_wins", 32'(bus.rom_addr), 32'd2);
        tick();
        check_output("stall.after_jump", 32'(bus.inst_out), 32'h12);

        // Reset mid-run under backpressure
        apply_reset();
        apply_start();
        wait_inst_pc(4'd2);
        inst_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst.valid", 32'(bus.inst_valid), 32'd0);
        check_output("rst.inst_out", 32'(bus.inst_out), 32'd0);
        check_output("rst.inst_pc", 32'(bus.inst_pc), 32'd0);
        check_output("rst.rom_addr", 32'(bus.rom_addr), 32'd0);
        check_output("rst.busy", 32'(busy), 32'd0);
        tick();
        tick();
        check_output("rst.no_fetch", 32'(bus.inst_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch sequencer for the 16-entry combinational instruction ROM (`inst_rom`). It owns the ROM address (program counter) and steps through the ROM. It handles start, halt-on-opcode, jump and stall. Fetched instructions are presented to the downstream decode stage through a single-entry valid/ready output register. It replaces free-running address counters used in bring-up benches with a controlled fetch path.

## Interface
- `ADDR_W`, 4: ROM address width; ROM depth is 2^ADDR_W.
- `DATA_W`, 8: instruction width.
- `START_ADDR`, 0: pc loaded on `start`.
- `WRAP_ADDR`, 1: pc value following the last address (2^ADDR_W-1).
- `HALT_OP`, 8'hFF: opcode that stops fetching after it is delivered.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin/restart fetching at START_ADDR (honoured in IDLE and HALT only).
- `stall`  in  1  freeze fetch (no ROM load, pc holds).
- `jump_en`  in  1  redirect pc (honoured in RUN only).
- `jump_addr`  in  ADDR_W  jump target.
- `rom_addr`  out  ADDR_W  address to ROM `inst` input; equals registered pc.
- `rom_data`  in  DATA_W  ROM `instrom` output (combinational, same cycle).
- `inst_out`  out  DATA_W  fetched instruction.
- `inst_pc`  out  ADDR_W  address inst_out was fetched from.
- `inst_valid`  out  1  inst_out valid.
- `inst_ready`  in  1  downstream accepts; transfer when inst_valid && inst_ready.
- `busy`  out  1  state == RUN.
- `halted`  out  1  state == HALT.

## Operation
- States: IDLE, RUN, HALT. Reset: state IDLE, pc=0, inst_out=0, inst_pc=0, inst_valid=0, so busy=0 and halted=0.
- IDLE: no loads. start → RUN, pc ← START_ADDR.
- RUN, load condition: load = !stall && !jump_en && (!inst_valid || inst_ready).
- On load: inst_out ← rom_data, inst_pc ← pc, inst_valid ← 1.
  - If rom_data == HALT_OP: → HALT, pc holds.
  - Otherwise pc ← next(pc).
- RUN, no load: if inst_valid && inst_ready, then inst_valid ← 0; otherwise the output holds.
- RUN, jump_en: pc ← jump_addr and inst_valid ← 0, flushing any unaccepted instruction. No load that cycle. jump_en has priority over stall and load. Any simultaneous transfer still counts as consumed.
- HALT: no loads; pc holds. A transfer clears inst_valid. start → RUN, pc ← START_ADDR, inst_valid ← 0 (a pending HALT_OP is dropped). jump_en is ignored.
- next(pc): if pc == 2^ADDR_W-1 then WRAP_ADDR, else pc+1 (ADDR_W-bit, no carry out).
- start in RUN, and jump_en/stall in IDLE/HALT, are ignored.

## Timing
- rom_addr is registered, so ROM data is sampled in the same cycle it is addressed.
- start sampled at edge k → RUN after k; rom_addr = START_ADDR during cycle k+1; inst_valid=1, inst_out=ROM[START_ADDR] after edge k+1 (latency 2 edges from start).
- Throughput: with inst_ready=1 and no stall, one instruction per cycle with back-to-back inst_valid.
- Backpressure: while inst_valid && !inst_ready, inst_out, inst_pc and pc are stable. No instruction is skipped or duplicated.
- Jump at edge j: inst_valid=0 after j; ROM[jump_addr] is valid after edge j+1.
- HALT_OP fetched at edge h: halted=1 and busy=0 after h; HALT_OP is held on inst_out until accepted.
- rst overrides everything at the next edge, including mid-RUN, mid-backpressure and HALT.

## Test plan
- Free run: ROM[i]=8'h10+i, no HALT_OP, ready=1, start pulse. Required: inst_pc sequence 0,1,…,15,1,2,… and inst_out 8'h10…8'h1F, 8'h11, 8'h12; inst_valid continuous from 2 edges after start.
- Backpressure: inst_ready low for 3 cycles while inst_pc=4. Required: inst_out=8'h14 held for 4 cycles, then 8'h15 follows, with no gap beyond the hold and no skip.
- Jump: assert jump_en with jump_addr=9 while inst_valid=1 and inst_pc=3, ready=0. Required: inst_valid=0 for one cycle, then inst_out=ROM[9] and inst_pc=9, then 10.
- Halt: ROM[5]=8'hFF, ready=1. Required: delivers pc 0–5, halted=1 after the fetch at 5, inst_valid=0 after acceptance, rom_addr stays 5. Then start re-fetches from pc 0.
- Stall plus simultaneous events: stall for 2 cycles at pc=7 gives no loads and pc=7 held. Then stall and jump_en(addr 2) together: the jump wins and pc=2.
- Reset mid-run: assert rst while busy with inst_valid=1. Required after the next edge: inst_valid=0, inst_out=0, inst_pc=0, rom_addr=0, busy=0, halted=0, and no fetch until start.
